// File: rtl/addsub_rr_arbiter.sv
// addsub_rr_arbiter: round-robin front end for one shared ripple-carry add/sub datapath.
// The winning requester's operands are registered onto the datapath. The result is
// captured after SETTLE cycles and returned with the requester index on a
// valid/ready response channel.
module addsub_rr_arbiter #(
    parameter int NREQ   = 4,
    parameter int WIDTH  = 16,
    parameter int IDW    = 2,
    parameter int SETTLE = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ-1:0]       req_ctrl,
    output logic [WIDTH-1:0]      dp_a,
    output logic [WIDTH-1:0]      dp_b,
    output logic                  dp_ctrl,
    input  logic [WIDTH-1:0]      dp_s,
    input  logic [WIDTH-1:0]      dp_cout,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WIDTH-1:0]      rsp_sum,
    output logic                  rsp_carry,
    output logic                  rsp_ovf,
    output logic [IDW-1:0]        rsp_id,
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [3:0] SETTLE_M1 = 4'(SETTLE - 1);

    state_t           state_q, state_d;
    logic [IDW-1:0]   last_q, last_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] dp_a_q, dp_a_d;
    logic [WIDTH-1:0] dp_b_q, dp_b_d;
    logic             dp_ctrl_q, dp_ctrl_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] rsp_sum_q, rsp_sum_d;
    logic             rsp_carry_q, rsp_carry_d;
    logic             rsp_ovf_q, rsp_ovf_d;
    logic [IDW-1:0]   rsp_id_q, rsp_id_d;

    logic             grant_found;
    logic [IDW-1:0]   grant_idx;
    logic [NREQ-1:0]  grant_oh;
    logic [WIDTH-1:0] grant_a;
    logic [WIDTH-1:0] grant_b;
    logic             grant_ctrl;
    int               cand;
    logic             ovf_now;
    logic             unused_cout_bits;

    // Only the top carry leaves the datapath; the lower per-bit carries are ignored.
    assign unused_cout_bits = ^dp_cout[WIDTH-2:0];

    // Round-robin pick: walk from last+1 upward (wrapping) and take the first valid requester.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        grant_oh    = '0;
        grant_a     = '0;
        grant_b     = '0;
        grant_ctrl  = 1'b0;
        cand        = 0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = int'(last_q) + k;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            for (int i = 0; i < NREQ; i++) begin
                if (!grant_found && cand == i && req_valid[i]) begin
                    grant_found = 1'b1;
                    grant_idx   = IDW'(i);
                    grant_oh[i] = 1'b1;
                    grant_a     = req_a[i*WIDTH +: WIDTH];
                    grant_b     = req_b[i*WIDTH +: WIDTH];
                    grant_ctrl  = req_ctrl[i];
                end
            end
        end
    end

    // Signed overflow: subtract behaves as add with B's sign inverted.
    always_comb begin
        ovf_now = (dp_a_q[WIDTH-1] == (dp_b_q[WIDTH-1] ^ dp_ctrl_q)) &&
                  (dp_s[WIDTH-1] != dp_a_q[WIDTH-1]);
    end

    // Next-state logic for IDLE -> EXEC -> RESP; the granted index doubles as the response id.
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        dp_a_d      = dp_a_q;
        dp_b_d      = dp_b_q;
        dp_ctrl_d   = dp_ctrl_q;
        rsp_valid_d = rsp_valid_q;
        rsp_sum_d   = rsp_sum_q;
        rsp_carry_d = rsp_carry_q;
        rsp_ovf_d   = rsp_ovf_q;
        rsp_id_d    = rsp_id_q;
        case (state_q)
            IDLE: begin
                if (grant_found) begin
                    dp_a_d    = grant_a;
                    dp_b_d    = grant_b;
                    dp_ctrl_d = grant_ctrl;
                    last_d    = grant_idx;
                    cnt_d     = 4'd0;
                    state_d   = EXEC;
                end
            end
            EXEC: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == SETTLE_M1) begin
                    rsp_sum_d   = dp_s;
                    rsp_carry_d = dp_cout[WIDTH-1];
                    rsp_ovf_d   = ovf_now;
                    rsp_id_d    = last_q;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset points the pointer at NREQ-1 so requester 0 wins first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            last_q      <= IDW'(NREQ - 1);
            cnt_q       <= 4'd0;
            dp_a_q      <= '0;
            dp_b_q      <= '0;
            dp_ctrl_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_sum_q   <= '0;
            rsp_carry_q <= 1'b0;
            rsp_ovf_q   <= 1'b0;
            rsp_id_q    <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            dp_a_q      <= dp_a_d;
            dp_b_q      <= dp_b_d;
            dp_ctrl_q   <= dp_ctrl_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_carry_q <= rsp_carry_d;
            rsp_ovf_q   <= rsp_ovf_d;
            rsp_id_q    <= rsp_id_d;
        end
    end

    // Ready is only offered from IDLE, and is forced low while reset is held.
    assign req_ready = grant_oh & {NREQ{rst_n && (state_q == IDLE)}};
    assign busy      = (state_q != IDLE);
    assign dp_a      = dp_a_q;
    assign dp_b      = dp_b_q;
    assign dp_ctrl   = dp_ctrl_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_carry = rsp_carry_q;
    assign rsp_ovf   = rsp_ovf_q;
    assign rsp_id    = rsp_id_q;

endmodule

// File: doc/addsub_rr_arbiter.md
Name: addsub_rr_arbiter

Overview:
- Shares one combinational 16-bit ripple-carry adder/subtractor among NREQ requesters.
- Round-robin arbitration selects a requester and registers its operands onto the datapath inputs.
- After a programmable settle time, captures sum/carry/overflow and returns them with the requester ID over a valid/ready response channel.
- Sits between client blocks and the single shared add/sub datapath instance.

Parameters:
- NREQ, 4: number of requesters (2..8).
- WIDTH, 16: operand width; must match the datapath.
- IDW, 2: response ID width; must satisfy 2^IDW >= NREQ.
- SETTLE, 1: clock cycles the datapath is held before capture (1..15), to cover ripple delay.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NREQ  per-requester request valid.
- req_ready  output  NREQ  per-requester accept; one-hot or zero.
- req_a  input  NREQ*WIDTH  operand A; requester i occupies bits [i*WIDTH +: WIDTH].
- req_b  input  NREQ*WIDTH  operand B, same packing.
- req_ctrl  input  NREQ  0 = add, 1 = subtract (A-B).
- dp_a  output  WIDTH  registered operand A to the datapath.
- dp_b  output  WIDTH  registered operand B to the datapath.
- dp_ctrl  output  1  registered add/sub select to the datapath.
- dp_s  input  WIDTH  datapath sum.
- dp_cout  input  WIDTH  datapath per-bit carry vector; only bit WIDTH-1 is used.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  response accept.
- rsp_sum  output  WIDTH  captured result.
- rsp_carry  output  1  captured dp_cout[WIDTH-1]; for subtract, 1 = no borrow.
- rsp_ovf  output  1  signed overflow.
- rsp_id  output  IDW  index of the requester served.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset values (asynchronous, while rst_n is low):
  - State = IDLE.
  - All outputs 0, including dp_a, dp_b, dp_ctrl, rsp_*, req_ready and busy.
  - Round-robin pointer last = NREQ-1, so requester 0 has first priority.
  - Settle counter = 0.
- States: IDLE -> EXEC -> RESP -> IDLE.
- IDLE:
  - Grant g = first i with req_valid[i]=1, scanning last+1, last+2, … modulo NREQ.
  - req_ready[g] is asserted combinationally in the same cycle; all other bits are 0.
  - No grant when req_valid = 0.
  - On the clock edge with a grant:
    - dp_a <= A[g], dp_b <= B[g], dp_ctrl <= req_ctrl[g].
    - id <= g, last <= g, counter <= 0, state -> EXEC.
- EXEC:
  - Counter increments each cycle.
  - On the edge where counter == SETTLE-1:
    - rsp_sum <= dp_s, rsp_carry <= dp_cout[WIDTH-1], rsp_id <= id.
    - rsp_ovf per the rule below, computed from dp_a/dp_b/dp_ctrl/dp_s.
    - rsp_valid <= 1, state -> RESP.
  - Latency: rsp_valid rises SETTLE edges after the request handshake edge.
- RESP:
  - rsp_* are held stable while rsp_valid=1 and rsp_ready=0.
  - On an edge with rsp_ready=1: rsp_valid <= 0, state -> IDLE.
  - No new grant in the same cycle. Minimum spacing between handshakes on req_ready is SETTLE+2 cycles.
- req_ready is 0 in EXEC and RESP regardless of req_valid.
- dp_a, dp_b and dp_ctrl keep their last values until the next grant; they are not cleared after use.
- Overflow rule:
  - Add: ovf = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]).
  - Sub: ovf = (a[W-1] != b[W-1]) && (s[W-1] != a[W-1]).
- Requester contract:
  - A requester holds valid and operands stable until its ready is seen.
  - The arbiter samples operands only on the handshake edge, so a requester may drop valid in other cycles without effect.
- Fairness: a requester that keeps valid high is served within NREQ grants.
- Reset mid-operation: the in-flight result is discarded and rsp_valid drops immediately on rst_n low. After release, arbitration restarts with requester 0 first.

Test Plan:
- Single add:
  - Stimulus: after reset, req0 asserts A=0x7FFF, B=0x0001, ctrl=0; rsp_ready held 1.
  - Response: req_ready[0] pulses for 1 cycle. rsp_valid rises 1 edge later (SETTLE=1) with sum=0x8000, carry=0, ovf=1, id=0.
- Subtract with borrow:
  - Stimulus: req2 asserts A=5, B=7, ctrl=1.
  - Response: sum=0xFFFE, carry=0, ovf=0, id=2.
  - Also: A=0x8000, B=0x0001, ctrl=1 gives sum=0x7FFF, carry=1, ovf=1.
- Round robin: all four valids held high continuously -> grant order 0,1,2,3,0,1. No requester is granted twice before the others are served.
- Backpressure:
  - Stimulus: rsp_ready held low for 5 cycles after rsp_valid rises.
  - Response: rsp_sum/rsp_id are stable for all 5 cycles, req_ready stays 0 and busy=1. Release completes the handshake, and the next grant occurs one cycle after release.
- Settle parameter: with SETTLE=4 -> rsp_valid rises 4 edges after the handshake, and dp_a/dp_b stay constant throughout EXEC.
- Reset mid-op: assert rst_n low during EXEC -> all outputs 0 immediately. After release with req1 and req3 valid, requester 1 is granted first.
